// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } arb_state_t;

  // Access-size encoding, identical to datamem type_control
  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;

  typedef enum logic {
    REQ_C = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin grant with last-grant register
module rr_arb2
  import dmem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req_c,
  input  logic    req_d,
  input  logic    mask_c,
  input  logic    force_last_d,
  output logic    gnt_c,
  output logic    gnt_d,
  output req_id_t last_grant
);

  // Core wins a tie only when debug had the previous grant
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      if (req_c && !mask_c && (!req_d || last_grant == REQ_D)) begin
        gnt_c = 1'b1;
      end else if (req_d) begin
        gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || force_last_d) begin
      last_grant <= REQ_D;
    end else if (gnt_c) begin
      last_grant <= REQ_C;
    end else if (gnt_d) begin
      last_grant <= REQ_D;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the datamem port between core and debug requesters
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [1:0]            c_type,
  input  logic                  c_sign_ext,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_ready,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_type,
  input  logic                  d_sign_ext,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  d_halt,
  output logic                  c_stall,
  output logic                  halted,
  output logic                  mem_we,
  output logic [1:0]            mem_type,
  output logic                  mem_sign_ext,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  arb_state_t            state, state_nxt;
  req_id_t               last_grant;
  logic                  gnt_c, gnt_d;
  logic [1:0]            hold_type;
  logic                  hold_sign_ext;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_din;

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst          (rst),
    .req_c        (c_req),
    .req_d        (d_req),
    .mask_c       (state != ARB),
    .force_last_d (state == HALTED && !d_halt),
    .gnt_c        (gnt_c),
    .gnt_d        (gnt_d),
    .last_grant   (last_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // A core read granted in the ARB cycle is delivered during the drain cycle,
  // so draining never needs more than one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:        if (d_halt) state_nxt = HALT_DRAIN;
      HALT_DRAIN: state_nxt = d_halt ? HALTED : ARB;
      HALTED:     if (!d_halt) state_nxt = ARB;
      default:    state_nxt = ARB;
    endcase
  end

  assign c_ready = gnt_c;
  assign d_ready = gnt_d;
  assign c_stall = c_req & ~c_ready;
  assign halted  = (state == HALTED);

  // Idle cycles replay the last granted fields so the memory inputs stay quiet
  always_comb begin
    mem_we       = 1'b0;
    mem_type     = hold_type;
    mem_sign_ext = hold_sign_ext;
    mem_addr     = hold_addr;
    mem_din      = hold_din;
    if (gnt_c) begin
      mem_we       = c_we;
      mem_type     = c_type;
      mem_sign_ext = c_sign_ext;
      mem_addr     = c_addr;
      mem_din      = c_wdata;
    end else if (gnt_d) begin
      mem_we       = d_we;
      mem_type     = d_type;
      mem_sign_ext = d_sign_ext;
      mem_addr     = d_addr;
      mem_din      = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_type     <= TYPE_WORD;
      hold_sign_ext <= 1'b0;
      hold_addr     <= '0;
      hold_din      <= '0;
      c_rvalid      <= 1'b0;
      d_rvalid      <= 1'b0;
      c_rdata       <= '0;
      d_rdata       <= '0;
    end else begin
      if (gnt_c || gnt_d) begin
        hold_type     <= mem_type;
        hold_sign_ext <= mem_sign_ext;
        hold_addr     <= mem_addr;
        hold_din      <= mem_din;
      end
      c_rvalid <= gnt_c & ~c_we;
      d_rvalid <= gnt_d & ~d_we;
      if (gnt_c && !c_we) c_rdata <= mem_dout;
      if (gnt_d && !d_we) d_rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a byte-addressed memory model
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, c_sign_ext, c_ready, c_rvalid;
  logic [1:0]    c_type;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_sign_ext, d_ready, d_rvalid;
  logic [1:0]    d_type;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_halt, c_stall, halted;
  logic          mem_we, mem_sign_ext;
  logic [1:0]    mem_type;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t c_q[$];
  exp_t d_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_type(c_type), .c_sign_ext(c_sign_ext),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_sign_ext(d_sign_ext),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_halt(d_halt), .c_stall(c_stall), .halted(halted),
    .mem_we(mem_we), .mem_type(mem_type), .mem_sign_ext(mem_sign_ext),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Little-endian byte memory standing in for datamem
  logic [7:0] mem [0:255];
  logic [7:0] ma0, ma1, ma2, ma3;

  always_comb begin
    ma0 = mem_addr[7:0];
    ma1 = ma0 + 8'd1;
    ma2 = ma0 + 8'd2;
    ma3 = ma0 + 8'd3;
    case (mem_type)
      TYPE_BYTE: mem_dout = {{24{mem_sign_ext & mem[ma0][7]}}, mem[ma0]};
      TYPE_HALF: mem_dout = {{16{mem_sign_ext & mem[ma1][7]}}, mem[ma1], mem[ma0]};
      default:   mem_dout = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[ma0] <= mem_din[7:0];
      if (mem_type != TYPE_BYTE) mem[ma1] <= mem_din[15:8];
      if (mem_type == TYPE_WORD) begin
        mem[ma2] <= mem_din[23:16];
        mem[ma3] <= mem_din[31:24];
      end
    end
  end

  // Scoreboard: each read grant must return its data exactly one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (c_rvalid) begin
      n_checks++;
      if (c_q.size() == 0) begin
        n_fail++;
        $display("FAIL c_rvalid_unexpected got rdata=%08h at cycle %0d, required no rvalid", c_rdata, cyc);
      end else begin
        e = c_q.pop_front();
        if (c_rdata !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL c_rdata_sb got %08h@%0d required %08h@%0d", c_rdata, cyc, e.data, e.due);
        end
      end
    end else if (c_q.size() != 0 && c_q[0].due <= cyc) begin
      n_checks++;
      n_fail++;
      e = c_q.pop_front();
      $display("FAIL c_rvalid_missing got none at cycle %0d required %08h@%0d", cyc, e.data, e.due);
    end
    if (d_rvalid) begin
      n_checks++;
      if (d_q.size() == 0) begin
        n_fail++;
        $display("FAIL d_rvalid_unexpected got rdata=%08h at cycle %0d, required no rvalid", d_rdata, cyc);
      end else begin
        e = d_q.pop_front();
        if (d_rdata !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL d_rdata_sb got %08h@%0d required %08h@%0d", d_rdata, cyc, e.data, e.due);
        end
      end
    end else if (d_q.size() != 0 && d_q[0].due <= cyc) begin
      n_checks++;
      n_fail++;
      e = d_q.pop_front();
      $display("FAIL d_rvalid_missing got none at cycle %0d required %08h@%0d", cyc, e.data, e.due);
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [1:0] ty,
                         input logic se, input logic [31:0] addr, input logic [31:0] wd);
    c_req = req; c_we = we; c_type = ty; c_sign_ext = se; c_addr = addr; c_wdata = wd;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [1:0] ty,
                         input logic se, input logic [31:0] addr, input logic [31:0] wd);
    d_req = req; d_we = we; d_type = ty; d_sign_ext = se; d_addr = addr; d_wdata = wd;
  endtask

  task automatic idle_inputs();
    drive_c(1'b0, 1'b0, TYPE_WORD, 1'b0, 32'h0, 32'h0);
    drive_d(1'b0, 1'b0, TYPE_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic sample_push(input logic [31:0] c_exp, input logic [31:0] d_exp);
    exp_t e;
    if (c_ready && !c_we) begin e.data = c_exp; e.due = cyc + 1; c_q.push_back(e); end
    if (d_ready && !d_we) begin e.data = d_exp; e.due = cyc + 1; d_q.push_back(e); end
  endtask

  task automatic test_reset();
    rst = 1'b1; d_halt = 1'b0;
    idle_inputs();
    cyc_start();
    drive_c(1'b1, 1'b1, TYPE_WORD, 1'b0, 32'h40, 32'h12345678);
    #2;
    n_checks++;
    if (c_ready !== 1'b0 || mem_we !== 1'b0 || c_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_rst got ready=%b we=%b stall=%b required 0 0 1", c_ready, mem_we, c_stall);
    end
    cyc_start();
    rst = 1'b0;
    idle_inputs();
    #2;
    n_checks++;
    if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || halted !== 1'b0 || c_ready !== 1'b0 || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got crv=%b drv=%b halted=%b crdy=%b drdy=%b required all 0",
               c_rvalid, d_rvalid, halted, c_ready, d_ready);
    end
    n_checks++;
    if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got c=%08h d=%08h required 0 0", c_rdata, d_rdata);
    end
  endtask

  task automatic test_core_only();
    cyc_start();
    drive_c(1'b1, 1'b1, TYPE_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    #2;
    n_checks++;
    if (c_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_din !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL core_write got ready=%b we=%b addr=%h din=%h required 1 1 10 deadbeef",
               c_ready, mem_we, mem_addr, mem_din);
    end
    cyc_start();
    drive_c(1'b1, 1'b0, TYPE_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    n_checks++;
    if (c_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL core_read_grant got ready=%b we=%b required 1 0", c_ready, mem_we);
    end
    sample_push(32'hDEADBEEF, 32'h0);
    cyc_start();
    idle_inputs();
    #2;
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL core_read_data got rvalid=%b rdata=%08h we=%b required 1 deadbeef 0", c_rvalid, c_rdata, mem_we);
    end
  endtask

  task automatic test_byte_sign();
    cyc_start();
    drive_d(1'b1, 1'b1, TYPE_BYTE, 1'b0, 32'h3, 32'h80);
    #2;
    n_checks++;
    if (d_ready !== 1'b1 || mem_we !== 1'b1 || mem_type !== TYPE_BYTE) begin
      n_fail++;
      $display("FAIL byte_write got ready=%b we=%b type=%b required 1 1 00", d_ready, mem_we, mem_type);
    end
    cyc_start();
    drive_d(1'b0, 1'b0, TYPE_WORD, 1'b0, 32'h0, 32'h0);
    drive_c(1'b1, 1'b0, TYPE_BYTE, 1'b1, 32'h3, 32'h0);
    #2;
    sample_push(32'hFFFFFF80, 32'h0);
    cyc_start();
    drive_c(1'b1, 1'b0, TYPE_BYTE, 1'b0, 32'h3, 32'h0);
    #2;
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL byte_signed got rvalid=%b rdata=%08h required 1 ffffff80", c_rvalid, c_rdata);
    end
    sample_push(32'h00000080, 32'h0);
    cyc_start();
    idle_inputs();
    #2;
    n_checks++;
    if (c_rdata !== 32'h00000080) begin
      n_fail++;
      $display("FAIL byte_unsigned got rdata=%08h required 00000080", c_rdata);
    end
  endtask

  task automatic test_contention();
    cyc_start();
    drive_d(1'b1, 1'b1, TYPE_WORD, 1'b0, 32'h0, 32'h11111111);
    cyc_start();
    drive_d(1'b1, 1'b1, TYPE_WORD, 1'b0, 32'h4, 32'h22222222);
    cyc_start();
    rst = 1'b1;
    idle_inputs();
    cyc_start();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc_start();
      drive_c(1'b1, 1'b0, TYPE_WORD, 1'b0, 32'h0, 32'h0);
      drive_d(1'b1, 1'b0, TYPE_WORD, 1'b0, 32'h4, 32'h0);
      #2;
      n_checks++;
      if (c_ready !== (k % 2 == 0) || d_ready !== (k % 2 == 1) || c_stall !== (k % 2 == 1)) begin
        n_fail++;
        $display("FAIL contention_grant%0d got c=%b d=%b stall=%b required c=%0d d=%0d stall=%0d",
                 k, c_ready, d_ready, c_stall, (k % 2 == 0), (k % 2 == 1), (k % 2 == 1));
      end
      sample_push(32'h11111111, 32'h22222222);
    end
    cyc_start();
    idle_inputs();
  endtask

  task automatic test_halt();
    int core_grants;
    int halt_k;
    core_grants = 0;
    halt_k = -1;
    cyc_start();
    drive_c(1'b1, 1'b0, TYPE_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    sample_push(32'hDEADBEEF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc_start();
      d_halt = 1'b1;
      #2;
      if (c_ready) core_grants++;
      if (halted && halt_k < 0) halt_k = k;
      if (halted) begin
        n_checks++;
        if (c_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL halt_c_ready got %b required 0 (k=%0d)", c_ready, k);
        end
      end
      sample_push(32'hDEADBEEF, 32'h0);
    end
    n_checks++;
    if (core_grants > 1) begin
      n_fail++;
      $display("FAIL halt_core_grants got %0d required <=1", core_grants);
    end
    n_checks++;
    if (halt_k < 0 || halt_k > 2) begin
      n_fail++;
      $display("FAIL halt_latency got %0d required 0..2", halt_k);
    end
    cyc_start();
    drive_d(1'b1, 1'b1, TYPE_BYTE, 1'b0, 32'h20, 32'hAB);
    #2;
    n_checks++;
    if (d_ready !== 1'b1 || mem_we !== 1'b1 || c_ready !== 1'b0 || c_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_d_write got drdy=%b we=%b crdy=%b stall=%b required 1 1 0 1", d_ready, mem_we, c_ready, c_stall);
    end
    cyc_start();
    drive_d(1'b0, 1'b0, TYPE_WORD, 1'b0, 32'h0, 32'h0);
    d_halt = 1'b0;
    #2;
    n_checks++;
    if (c_ready !== 1'b0 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_release_cycle got crdy=%b halted=%b required 0 1", c_ready, halted);
    end
    cyc_start();
    drive_d(1'b1, 1'b0, TYPE_BYTE, 1'b0, 32'h20, 32'h0);
    #2;
    n_checks++;
    if (c_ready !== 1'b1 || d_ready !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_resume got crdy=%b drdy=%b halted=%b required 1 0 0", c_ready, d_ready, halted);
    end
    sample_push(32'hDEADBEEF, 32'h000000AB);
    cyc_start();
    #2;
    n_checks++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_resume_rr got drdy=%b required 1", d_ready);
    end
    sample_push(32'hDEADBEEF, 32'h000000AB);
    cyc_start();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    cyc_start();
    drive_c(1'b1, 1'b0, TYPE_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    sample_push(32'hDEADBEEF, 32'h0);
    cyc_start();
    rst = 1'b1;
    drive_c(1'b1, 1'b1, TYPE_WORD, 1'b0, 32'h10, 32'hBAD0BAD0);
    #2;
    n_checks++;
    if (c_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_write got ready=%b we=%b required 0 0", c_ready, mem_we);
    end
    cyc_start();
    rst = 1'b0;
    drive_c(1'b1, 1'b0, TYPE_WORD, 1'b0, 32'h10, 32'h0);
    drive_d(1'b1, 1'b0, TYPE_BYTE, 1'b0, 32'h20, 32'h0);
    #2;
    n_checks++;
    if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_read got rvalid=%b rdata=%08h required 0 0", c_rvalid, c_rdata);
    end
    n_checks++;
    if (c_ready !== 1'b1 || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_first_tie got c=%b d=%b required 1 0", c_ready, d_ready);
    end
    sample_push(32'hDEADBEEF, 32'h000000AB);
    cyc_start();
    drive_c(1'b0, 1'b0, TYPE_WORD, 1'b0, 32'h0, 32'h0);
    #2;
    sample_push(32'hDEADBEEF, 32'h000000AB);
    cyc_start();
    idle_inputs();
  endtask

  task automatic test_idle_hold();
    cyc_start();
    drive_c(1'b1, 1'b0, TYPE_WORD, 1'b0, 32'h10, 32'h0);
    #2;
    sample_push(32'hDEADBEEF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      cyc_start();
      idle_inputs();
      #2;
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h10 || mem_type !== TYPE_WORD) begin
        n_fail++;
        $display("FAIL idle_hold%0d got we=%b addr=%h type=%b required 0 10 10", k, mem_we, mem_addr, mem_type);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_core_only();
    test_byte_sign();
    test_contention();
    test_halt();
    test_reset_mid_read();
    test_idle_hold();
    cyc_start();
    cyc_start();
    #2;
    n_checks++;
    if (c_q.size() != 0 || d_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got c=%0d d=%0d pending required 0 0", c_q.size(), d_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
